mem_wb_skid_reg: RTL and testbench

- Parametrised MEM/WB pipeline register between data memory and register-file write-back.
- Successor to the plain always-clocked stage register. Adds valid/ready handshake, a 2-entry skid buffer for back-pressure, synchronous flush and asynchronous reset.
- Also provides a pre-muxed write-back data/enable pair for the register file and the forwarding unit.
- Fields are held only while valid; bubbles never write the register file.

---
 rtl/mem_wb_skid_reg.sv | 198 +++++++++++++++++++
 tb/tb_mem_wb_skid_reg.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_wb_skid_reg
// Purpose  : MEM/WB pipeline register with a valid/ready handshake.
//            A two-entry skid buffer absorbs back-pressure, so in_ready
//            depends only on state. The stage also provides pre-muxed
//            write-back data and enable for the register file and the
//            forwarding unit.
// Option   : define MEM_WB_PERF_CNT_EN to add the retire_cnt and
//            stall_cnt performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_skid_reg #(
  parameter int DATA_W         = 32,
  parameter int RD_W           = 5,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mem_to_reg,
  output logic              out_reg_write,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  // One held pipeline entry.
  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
  } entry_t;

  // EMPTY: nothing held. MAIN: head only. FULL: head plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_main_next;
  entry_t w_skid_next;
  entry_t w_in_entry;

  logic w_accept;
  logic w_pop;
  logic w_rd_zero;
  logic w_guard_hit;
  logic w_wb_en;

  // Pack the incoming fields into one entry.
  assign w_in_entry.mem_to_reg = in_mem_to_reg;
  assign w_in_entry.reg_write  = in_reg_write;
  assign w_in_entry.rd         = in_rd;
  assign w_in_entry.alu_result = in_alu_result;
  assign w_in_entry.read_data  = in_read_data;

  // Handshake. in_ready decodes the state register only, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Next state and next entry contents. Flush overrides any accept in the
  // same cycle. Slots that become empty are zeroed, so the outputs never
  // show stale data.
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    if (flush) begin
      w_state_next = ST_EMPTY;
      w_main_next  = '0;
      w_skid_next  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_MAIN;
            w_main_next  = w_in_entry;
          end
        end
        ST_MAIN: begin
          case ({w_accept, w_pop})
            2'b11: begin
              // The head retires and the new entry takes its place.
              w_main_next = w_in_entry;
            end
            2'b10: begin
              // The head is stalled, so the new entry parks in the skid slot.
              w_state_next = ST_FULL;
              w_skid_next  = w_in_entry;
            end
            2'b01: begin
              w_state_next = ST_EMPTY;
              w_main_next  = '0;
            end
            default: begin
            end
          endcase
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_next = ST_MAIN;
            w_main_next  = r_skid;
            w_skid_next  = '0;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
          w_main_next  = '0;
          w_skid_next  = '0;
        end
      endcase
    end
  end

  // Register the state and both entries. Reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_next;
      r_main  <= w_main_next;
      r_skid  <= w_skid_next;
    end
  end

  // The head entry drives the outputs.
  assign out_mem_to_reg = r_main.mem_to_reg;
  assign out_reg_write  = r_main.reg_write;
  assign out_rd         = r_main.rd;
  assign out_alu_result = r_main.alu_result;
  assign out_read_data  = r_main.read_data;

  // Write-back mux and enable. A bubble never writes the register file, and
  // x0 stays read-only when the guard is enabled.
  assign wb_data     = r_main.mem_to_reg ? r_main.read_data : r_main.alu_result;
  assign w_rd_zero   = (r_main.rd == '0);
  assign w_guard_hit = (ZERO_REG_GUARD != 0) && w_rd_zero;
  assign w_wb_en     = w_pop & r_main.reg_write & ~w_guard_hit;
  assign wb_en       = w_wb_en;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] r_retire_cnt;
  logic [31:0] r_stall_cnt;

  // Count register-file writes and blocked upstream cycles. Both counters
  // wrap, and only reset clears them; flush leaves them unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire_cnt <= 32'd0;
      r_stall_cnt  <= 32'd0;
    end else begin
      if (w_wb_en) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      if (in_valid && !in_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  // Without the counters, the stage is just the handshake register above.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_skid_reg
// Purpose  : Self-checking bench for mem_wb_skid_reg. A queue-based model
//            (capacity two) predicts the outputs. A second instance with
//            ZERO_REG_GUARD=0 covers the unguarded write enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_skid_reg;

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_m2r;
  logic        in_rw;
  logic [4:0]  in_rd;
  logic [31:0] in_alu;
  logic [31:0] in_rdata;
  logic        out_ready;

  logic        in_ready, out_valid, out_m2r, out_rw, wb_en;
  logic [4:0]  out_rd;
  logic [31:0] out_alu, out_rdata, wb_data;

  logic        g0_in_ready, g0_out_valid, g0_out_m2r, g0_out_rw, g0_wb_en;
  logic [4:0]  g0_out_rd;
  logic [31:0] g0_out_alu, g0_out_rdata, g0_wb_data;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt, g0_retire_cnt, g0_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  ent_t        q[$];
  logic [31:0] m_retire;
  logic [31:0] m_stall;

  mem_wb_skid_reg #(.DATA_W(32), .RD_W(5), .ZERO_REG_GUARD(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_to_reg(in_m2r), .in_reg_write(in_rw), .in_rd(in_rd),
    .in_alu_result(in_alu), .in_read_data(in_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mem_to_reg(out_m2r), .out_reg_write(out_rw), .out_rd(out_rd),
    .out_alu_result(out_alu), .out_read_data(out_rdata),
    .wb_data(wb_data), .wb_en(wb_en)
`ifdef MEM_WB_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  mem_wb_skid_reg #(.DATA_W(32), .RD_W(5), .ZERO_REG_GUARD(0)) dut_g0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(g0_in_ready),
    .in_mem_to_reg(in_m2r), .in_reg_write(in_rw), .in_rd(in_rd),
    .in_alu_result(in_alu), .in_read_data(in_rdata),
    .out_valid(g0_out_valid), .out_ready(out_ready),
    .out_mem_to_reg(g0_out_m2r), .out_reg_write(g0_out_rw), .out_rd(g0_out_rd),
    .out_alu_result(g0_out_alu), .out_read_data(g0_out_rdata),
    .wb_data(g0_wb_data), .wb_en(g0_wb_en)
`ifdef MEM_WB_PERF_CNT_EN
    , .retire_cnt(g0_retire_cnt), .stall_cnt(g0_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock. The model uses the inputs held before the edge: a
  // queue with room for two entries, where flush empties it.
  task automatic tick();
    bit   ready;
    bit   acc;
    bit   pp;
    ent_t e;
    ready = (q.size() < 2);
    acc   = in_valid && ready;
    pp    = (q.size() > 0) && out_ready;
    if (in_valid && !ready) m_stall = m_stall + 32'd1;
    if (pp) begin
      if (q[0].rw && (q[0].rd != 5'd0)) m_retire = m_retire + 32'd1;
    end
    e.m2r   = in_m2r;
    e.rw    = in_rw;
    e.rd    = in_rd;
    e.alu   = in_alu;
    e.rdata = in_rdata;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic set_in(input bit v, input bit m2r, input bit rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdata);
    in_valid = v;
    in_m2r   = m2r;
    in_rw    = rw;
    in_rd    = rd;
    in_alu   = alu;
    in_rdata = rdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    q.delete();
    m_retire = 32'd0;
    m_stall  = 32'd0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (wb_en !== 1'b0 || g0_wb_en !== 1'b0) begin
      failures++; $display("FAIL reset_wb_en got=%b/%b exp=0/0", wb_en, g0_wb_en);
    end
    checks++;
    if ({out_m2r, out_rw, out_rd, out_alu, out_rdata, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_payload got m2r=%b rw=%b rd=%h alu=%h rdata=%h wb=%h exp=all zero",
               out_m2r, out_rw, out_rd, out_alu, out_rdata, wb_data);
    end
`ifdef MEM_WB_PERF_CNT_EN
    checks++;
    if (retire_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", retire_cnt, stall_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_single_push();
    out_ready = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 5'd5, 32'h10, 32'hDEADBEEF);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL push_out_valid got=%b exp=1", out_valid); end
    checks++;
    if (wb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL push_wb_data got=%h exp=deadbeef", wb_data); end
    checks++;
    if (wb_en !== 1'b1) begin failures++; $display("FAIL push_wb_en got=%b exp=1", wb_en); end
    checks++;
    if (out_rd !== 5'd5 || out_alu !== 32'h10) begin
      failures++; $display("FAIL push_fields got rd=%0d alu=%h exp rd=5 alu=10", out_rd, out_alu);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] a_alu;
    logic [31:0] b_alu;
    a_alu = $urandom;
    b_alu = $urandom;
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 1'b1, 5'd1, a_alu, 32'h0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 5'd2, b_alu, 32'h0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 5'd3, 32'hC0C0C0C0, 32'h0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_rd !== 5'd1 || wb_en !== 1'b0) begin
      failures++; $display("FAIL bp_stalled_head got rd=%0d wb_en=%b exp rd=1 wb_en=0", out_rd, wb_en);
    end
    tick();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_alu !== a_alu || wb_data !== a_alu) begin
      failures++;
      $display("FAIL bp_retire_a got v=%b rd=%0d alu=%h wb=%h exp v=1 rd=1 alu=%h",
               out_valid, out_rd, out_alu, wb_data, a_alu);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_alu !== b_alu || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_retire_b got v=%b rd=%0d alu=%h rdy=%b exp v=1 rd=2 alu=%h rdy=1",
               out_valid, out_rd, out_alu, in_ready, b_alu);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_c_dropped got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    out_ready = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 5'd0, 32'h7, 32'h5555AAAA);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (wb_data !== 32'h7) begin failures++; $display("FAIL zero_wb_data got=%h exp=7", wb_data); end
    checks++;
    if (wb_en !== 1'b0) begin failures++; $display("FAIL zero_guarded_wb_en got=%b exp=0", wb_en); end
    checks++;
    if (g0_wb_en !== 1'b1) begin failures++; $display("FAIL zero_unguarded_wb_en got=%b exp=1", g0_wb_en); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 5'd9, 32'h1, 32'h2);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 5'd10, 32'h3, 32'h4);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 5'd11, 32'h5, 32'h6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || wb_en !== 1'b0) begin
      failures++; $display("FAIL flush_state got v=%b rdy=%b wb_en=%b exp 0/1/0", out_valid, in_ready, wb_en);
    end
    checks++;
    if (out_rd !== 5'd0 || out_alu !== 32'd0 || out_rdata !== 32'd0) begin
      failures++; $display("FAIL flush_payload got rd=%0d alu=%h rdata=%h exp zero", out_rd, out_alu, out_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_retire got v=%b exp=0", out_valid); end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_in(1'b1, 1'b0, 1'b1, 5'd4, 32'h44, 32'h0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 5'd6, 32'h66, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_rd !== 5'd0) begin
      failures++;
      $display("FAIL async_reset got v=%b rdy=%b rd=%0d exp 0/1/0", out_valid, in_ready, out_rd);
    end
    q.delete();
    m_retire = 32'd0;
    m_stall  = 32'd0;
    @(posedge clk);
    #3 reset = 1'b0;
`ifdef MEM_WB_PERF_CNT_EN
    set_in(1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 32'h0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 5'd8, 32'h88, 32'h0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd1 || retire_cnt !== 32'd0) begin
      failures++; $display("FAIL perf_stall got stall=%0d retire=%0d exp 1/0", stall_cnt, retire_cnt);
    end
    out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (retire_cnt !== 32'd2 || stall_cnt !== 32'd1) begin
      failures++; $display("FAIL perf_retire got retire=%0d stall=%0d exp 2/1", retire_cnt, stall_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    ent_t got;
    ent_t exp;
    bit   exp_v;
    bit   exp_en;
    bit   exp_en0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 4);
      in_m2r    = 1'($urandom_range(0, 1));
      in_rw     = ($urandom_range(0, 3) != 0);
      in_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      in_alu    = $urandom;
      in_rdata  = $urandom;
      @(negedge clk);
      exp_v   = (q.size() > 0);
      exp     = exp_v ? q[0] : '0;
      exp_en0 = exp_v && out_ready && exp.rw;
      exp_en  = exp_en0 && (exp.rd != 5'd0);
      got     = {out_m2r, out_rw, out_rd, out_alu, out_rdata};
      checks++;
      if (out_valid !== exp_v || in_ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rand_handshake cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b",
                 i, out_valid, in_ready, exp_v, (q.size() < 2));
      end
      if (exp_v) begin
        checks++;
        if (got !== exp || wb_data !== (exp.m2r ? exp.rdata : exp.alu)) begin
          failures++;
          $display("FAIL rand_head cyc=%0d got=%h wb=%h exp=%h", i, got, wb_data, exp);
        end
      end
      checks++;
      if (wb_en !== exp_en || g0_wb_en !== exp_en0) begin
        failures++;
        $display("FAIL rand_wb_en cyc=%0d got=%b/%b exp=%b/%b", i, wb_en, g0_wb_en, exp_en, exp_en0);
      end
`ifdef MEM_WB_PERF_CNT_EN
      checks++;
      if (retire_cnt !== m_retire || stall_cnt !== m_stall) begin
        failures++;
        $display("FAIL rand_counters cyc=%0d got=%0d/%0d exp=%0d/%0d",
                 i, retire_cnt, stall_cnt, m_retire, m_stall);
      end
`endif
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_back_pressure();
    test_zero_reg();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
